opnd_fetch_sched: RTL and testbench

//  Sequencer after decode_opnds. Takes one decoded instruction's operand descriptors
//  (kind/size per operand, register values, immediate, effective address) and resolves every operand.

---
 rtl/opnd_fetch_sched.sv | 212 +++++++++++++++++++++
 tb/tb_opnd_fetch_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opnd_fetch_sched.sv
// Operand fetch sequencer: resolves register/immediate/memory operands of one decoded
// instruction, fetching a memory operand through a single aligned 32-bit read port.
module opnd_fetch_sched #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_kind,
    input  logic [1:0]  in_size,
    input  logic [31:0] in_reg0,
    input  logic [31:0] in_reg1,
    input  logic [31:0] in_reg2,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_ea,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_opnd0,
    output logic [31:0] out_opnd1,
    output logic [31:0] out_opnd2,
    output logic        out_fault
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ_LO  = 3'd1;
    localparam logic [2:0] WAIT_LO = 3'd2;
    localparam logic [2:0] REQ_HI  = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;
    localparam logic [2:0] OUT     = 3'd5;

    localparam logic [1:0] K_REG = 2'b01;
    localparam logic [1:0] K_IMM = 2'b10;
    localparam logic [1:0] K_MEM = 2'b11;

    // The counter reaching this value at the end of a silent WAIT cycle means MEM_TIMEOUT such cycles elapsed.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  state;
    logic [5:0]  kind_q;
    logic [1:0]  size_q;
    logic [31:0] reg0_q;
    logic [31:0] reg1_q;
    logic [31:0] reg2_q;
    logic [31:0] imm_q;
    logic [1:0]  ea_lo_q;
    logic [31:0] req_addr_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        fault_q;
    logic [7:0]  tmo_cnt;

    logic [1:0]  mem_count;
    logic [2:0]  size_bytes;
    logic [31:0] size_mask;
    logic        split;
    logic [63:0] merged_wide;
    logic [31:0] mem_data;

    function automatic logic [31:0] sel_opnd(input logic [1:0]  kind,
                                             input logic [31:0] regv,
                                             input logic [31:0] imm,
                                             input logic [31:0] mem,
                                             input logic [31:0] mask);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_REG:   v = regv & mask;
            K_IMM:   v = imm & mask;
            K_MEM:   v = mem;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign mem_count = {1'b0, &in_kind[1:0]} + {1'b0, &in_kind[3:2]} + {1'b0, &in_kind[5:4]};

    always_comb begin
        size_bytes = 3'd4;
        size_mask  = 32'hFFFF_FFFF;
        case (size_q)
            2'b00: begin
                size_bytes = 3'd1;
                size_mask  = 32'h0000_00FF;
            end
            2'b01: begin
                size_bytes = 3'd2;
                size_mask  = 32'h0000_FFFF;
            end
            default: begin
                size_bytes = 3'd4;
                size_mask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign split       = ({1'b0, ea_lo_q} + size_bytes) > 3'd4;
    // For an unsplit access the selected bytes all lie in lo, so a stale hi never reaches the result.
    assign merged_wide = {hi_q, lo_q} >> {ea_lo_q, 3'b000};
    assign mem_data    = merged_wide[31:0] & size_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            kind_q     <= '0;
            size_q     <= '0;
            reg0_q     <= '0;
            reg1_q     <= '0;
            reg2_q     <= '0;
            imm_q      <= '0;
            ea_lo_q    <= '0;
            req_addr_q <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            fault_q    <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        kind_q     <= in_kind;
                        size_q     <= in_size;
                        reg0_q     <= in_reg0;
                        reg1_q     <= in_reg1;
                        reg2_q     <= in_reg2;
                        imm_q      <= in_imm;
                        ea_lo_q    <= in_ea[1:0];
                        req_addr_q <= {in_ea[31:2], 2'b00};
                        lo_q       <= '0;
                        hi_q       <= '0;
                        if (mem_count > 2'd1 || (mem_count != 2'd0 && in_size == 2'b11)) begin
                            fault_q <= 1'b1;
                            state   <= OUT;
                        end else begin
                            fault_q <= 1'b0;
                            state   <= (mem_count == 2'd0) ? OUT : REQ_LO;
                        end
                    end
                end
                REQ_LO: begin
                    if (mem_req_ready) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (mem_rsp_valid) begin
                        lo_q <= mem_rsp_data;
                        if (split) begin
                            req_addr_q <= req_addr_q + 32'd4;
                            state      <= REQ_HI;
                        end else begin
                            state <= OUT;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        fault_q <= 1'b1;
                        state   <= OUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                REQ_HI: begin
                    if (mem_req_ready) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (mem_rsp_valid) begin
                        hi_q  <= mem_rsp_data;
                        state <= OUT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fault_q <= 1'b1;
                        state   <= OUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ_LO) || (state == REQ_HI);
    assign mem_req_addr  = req_addr_q;
    assign out_valid     = (state == OUT);
    assign out_fault     = out_valid && fault_q;

    // Operands are resolved from held registers, so they stay stable while OUT stalls.
    always_comb begin
        out_opnd0 = '0;
        out_opnd1 = '0;
        out_opnd2 = '0;
        if (out_valid && !fault_q) begin
            out_opnd0 = sel_opnd(kind_q[1:0], reg0_q, imm_q, mem_data, size_mask);
            out_opnd1 = sel_opnd(kind_q[3:2], reg1_q, imm_q, mem_data, size_mask);
            out_opnd2 = sel_opnd(kind_q[5:4], reg2_q, imm_q, mem_data, size_mask);
        end
    end

endmodule

// File: tb/tb_opnd_fetch_sched.sv
// Scoreboard bench for opnd_fetch_sched: a small memory responder checks request addresses,
// and an output monitor compares each resolved bundle and its latency against queued expectations.
module tb_opnd_fetch_sched;

    typedef struct {
        logic [31:0] o0;
        logic [31:0] o1;
        logic [31:0] o2;
        logic        f;
        int          lat;
        int          nreq;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_kind;
    logic [1:0]  in_size;
    logic [31:0] in_reg0;
    logic [31:0] in_reg1;
    logic [31:0] in_reg2;
    logic [31:0] in_imm;
    logic [31:0] in_ea;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_opnd0;
    logic [31:0] out_opnd1;
    logic [31:0] out_opnd2;
    logic        out_fault;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int req_cnt = 0;
    int mem_delay = 0;
    bit mem_silent = 0;
    bit lat_seen = 0;

    exp_t        sb_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] rsp_q[$];

    opnd_fetch_sched #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_size(in_size),
        .in_reg0(in_reg0), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_imm(in_imm), .in_ea(in_ea),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opnd0(out_opnd0), .out_opnd1(out_opnd1), .out_opnd2(out_opnd2),
        .out_fault(out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder: answers each accepted request mem_delay cycles after its first possible slot.
    initial begin
        int pending;
        pending = 0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pending = 0;
            end else begin
                if (pending > 0) begin
                    pending--;
                    if (pending == 0 && !mem_silent && rsp_q.size() > 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = rsp_q.pop_front();
                    end
                end
                if (mem_req_valid && mem_req_ready) begin
                    req_cnt++;
                    if (exp_addr_q.size() == 0)
                        checkOutput("req_unexpected", 32'(exp_addr_q.size()), 32'd1);
                    else
                        checkOutput("req_addr", mem_req_addr, exp_addr_q.pop_front());
                    pending = mem_delay + 1;
                end
            end
        end
    end

    // Output monitor: latency on first sight of out_valid, contents on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_empty", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q[0];
                    if (!lat_seen) begin
                        checkOutput("latency", 32'(cyc - accept_cyc), 32'(e.lat));
                        lat_seen = 1;
                    end
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        lat_seen = 0;
                        checkOutput("opnd0", out_opnd0, e.o0);
                        checkOutput("opnd1", out_opnd1, e.o1);
                        checkOutput("opnd2", out_opnd2, e.o2);
                        checkOutput("fault", {31'b0, out_fault}, {31'b0, e.f});
                        checkOutput("req_count", 32'(req_cnt), 32'(e.nreq));
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [5:0] kind, input logic [1:0] size,
                                 input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] imm, input logic [31:0] ea,
                                 input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                                 input logic ef, input int lat, input int nreq, input bit track);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_wait", {31'b0, in_ready}, 32'd1);
            return;
        end
        in_kind  = kind;
        in_size  = size;
        in_reg0  = r0;
        in_reg1  = r1;
        in_reg2  = r2;
        in_imm   = imm;
        in_ea    = ea;
        in_valid = 1'b1;
        req_cnt    = 0;
        accept_cyc = cyc;
        if (track) begin
            e.o0 = e0; e.o1 = e1; e.o2 = e2; e.f = ef; e.lat = lat; e.nreq = nreq;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_kind = '0; in_size = '0;
        in_reg0 = '0; in_reg1 = '0; in_reg2 = '0; in_imm = '0; in_ea = '0;
        mem_req_ready = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("rst_req_addr", mem_req_addr, 32'd0);
        checkOutput("rst_opnd0", out_opnd0, 32'd0);
        checkOutput("rst_fault", {31'b0, out_fault}, 32'd0);
        rst_n = 1'b1;

        // Register pass-through, no memory traffic.
        applyStimulus({2'b00, 2'b01, 2'b01}, 2'b10, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0, 32'h0,
                      32'hDEADBEEF, 32'h12345678, 32'h0, 1'b0, 1, 0, 1);
        waitDrain();

        // IMM/MEM/REG mix, aligned dword.
        exp_addr_q.push_back(32'h1000);
        rsp_q.push_back(32'hCAFEF00D);
        applyStimulus({2'b10, 2'b11, 2'b01}, 2'b10, 32'h11111111, 32'h0, 32'h0, 32'h0000ABCD, 32'h1000,
                      32'h11111111, 32'hCAFEF00D, 32'h0000ABCD, 1'b0, 3, 1, 1);
        waitDrain();

        // Byte at the top lane never splits; REG operand masked to a byte.
        exp_addr_q.push_back(32'h1000);
        rsp_q.push_back(32'hAABBCCDD);
        applyStimulus({2'b00, 2'b01, 2'b11}, 2'b00, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h1003,
                      32'h000000AA, 32'h00000078, 32'h0, 1'b0, 3, 1, 1);
        waitDrain();

        // Split dword.
        exp_addr_q.push_back(32'h1000);
        exp_addr_q.push_back(32'h1004);
        rsp_q.push_back(32'h44332211);
        rsp_q.push_back(32'h88776655);
        applyStimulus({2'b00, 2'b00, 2'b11}, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1002,
                      32'h66554433, 32'h0, 32'h0, 1'b0, 5, 2, 1);
        waitDrain();

        // Split word across the top of the address space wraps to 0.
        exp_addr_q.push_back(32'hFFFFFFFC);
        exp_addr_q.push_back(32'h00000000);
        rsp_q.push_back(32'h44332211);
        rsp_q.push_back(32'h88776655);
        applyStimulus({2'b00, 2'b00, 2'b11}, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF,
                      32'h00005544, 32'h0, 32'h0, 1'b0, 5, 2, 1);
        waitDrain();

        // Timeout after 4 silent WAIT cycles: fault, operands zero.
        mem_silent = 1;
        exp_addr_q.push_back(32'h2000);
        applyStimulus({2'b00, 2'b01, 2'b11}, 2'b10, 32'h0, 32'h55555555, 32'h0, 32'h0, 32'h2000,
                      32'h0, 32'h0, 32'h0, 1'b1, 6, 1, 1);
        waitDrain();
        mem_silent = 0;

        // Response on the final WAIT cycle beats the timeout.
        mem_delay = 3;
        exp_addr_q.push_back(32'h3000);
        rsp_q.push_back(32'h01020304);
        applyStimulus({2'b00, 2'b00, 2'b11}, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3000,
                      32'h01020304, 32'h0, 32'h0, 1'b0, 6, 1, 1);
        waitDrain();
        mem_delay = 0;

        // Reset while a request is stalled.
        mem_req_ready = 1'b0;
        applyStimulus({2'b00, 2'b00, 2'b11}, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4000,
                      32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        @(negedge clk);
        checkOutput("stall_req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("stall_req_addr", mem_req_addr, 32'h4000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        mem_req_ready = 1'b1;

        // Two MEM operands fault without memory traffic; output held for 3 stalled cycles.
        out_ready = 1'b0;
        applyStimulus({2'b11, 2'b11, 2'b01}, 2'b10, 32'h5, 32'h0, 32'h0, 32'h0, 32'h5000,
                      32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("hold_fault", {31'b0, out_fault}, 32'd1);
            checkOutput("hold_opnd0", out_opnd0, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        waitDrain();

        // Illegal size with a MEM operand faults immediately.
        applyStimulus({2'b00, 2'b00, 2'b11}, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h6000,
                      32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 1);
        waitDrain();

        checkOutput("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
        checkOutput("rsp_q_left", 32'(rsp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
